// File: rtl/dual_sram_bist_pkg.sv
// Shared types and helpers for the dual-port SRAM March C- BIST controller:
// controller states, march direction, background patterns and the per-element
// operation table.
package dual_sram_bist_pkg;

    // Widest data word the background helper can produce.
    localparam int MAX_WIDTH = 64;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_M0,
        ST_M1,
        ST_M2,
        ST_M3,
        ST_M4,
        ST_M5,
        ST_XP,
        ST_DRAIN,
        ST_DONE
    } state_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    typedef enum logic [1:0] {
        BG_Z,   // all zeros
        BG_O,   // all ones
        BG_P    // alternating 1010..., MSB = 1
    } bg_e;

    // Operations performed at each relative index by one march element.
    typedef struct packed {
        logic has_rd;
        bg_e  rd_bg;
        logic has_wr;
        bg_e  wr_bg;
        dir_e dir;
    } march_elem_t;

    // Background word of the requested kind, 'width' bits wide, zero above.
    function automatic logic [MAX_WIDTH-1:0] background(input bg_e bg, input int width);
        logic [MAX_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i < width) begin
                unique case (bg)
                    BG_O:    v[i] = 1'b1;
                    BG_P:    v[i] = ((width - 1 - i) % 2) == 0;
                    default: v[i] = 1'b0;
                endcase
            end
        end
        return v;
    endfunction

    // Address order of a march element: M3 and M4 walk downwards.
    function automatic dir_e elem_dir(input state_e st);
        return (st == ST_M3 || st == ST_M4) ? DIR_DOWN : DIR_UP;
    endfunction

    // March C- operation table.
    function automatic march_elem_t march_elem(input state_e st);
        march_elem_t e;
        e = '{has_rd: 1'b0, rd_bg: BG_Z, has_wr: 1'b0, wr_bg: BG_Z, dir: elem_dir(st)};
        unique case (st)
            ST_M0: e = '{has_rd: 1'b0, rd_bg: BG_Z, has_wr: 1'b1, wr_bg: BG_Z, dir: elem_dir(st)};
            ST_M1: e = '{has_rd: 1'b1, rd_bg: BG_Z, has_wr: 1'b1, wr_bg: BG_O, dir: elem_dir(st)};
            ST_M2: e = '{has_rd: 1'b1, rd_bg: BG_O, has_wr: 1'b1, wr_bg: BG_Z, dir: elem_dir(st)};
            ST_M3: e = '{has_rd: 1'b1, rd_bg: BG_Z, has_wr: 1'b1, wr_bg: BG_O, dir: elem_dir(st)};
            ST_M4: e = '{has_rd: 1'b1, rd_bg: BG_O, has_wr: 1'b1, wr_bg: BG_Z, dir: elem_dir(st)};
            ST_M5: e = '{has_rd: 1'b1, rd_bg: BG_Z, has_wr: 1'b0, wr_bg: BG_Z, dir: elem_dir(st)};
            default: ;
        endcase
        return e;
    endfunction

    // Phase that follows a march element once its last index is done.
    function automatic state_e next_phase(input state_e st);
        state_e n;
        unique case (st)
            ST_M0:   n = ST_M1;
            ST_M1:   n = ST_M2;
            ST_M2:   n = ST_M3;
            ST_M3:   n = ST_M4;
            ST_M4:   n = ST_M5;
            ST_M5:   n = ST_XP;
            default: n = ST_IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/dual_sram_bist_check.sv
// Read-compare stage for both SRAM ports: holds the expectation of each read
// for one cycle, compares it with the returned data, counts mismatches
// (saturating) and captures the first failing address and port.
module dual_sram_bist_check #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  rd_valid_a,
    input  logic [WIDTH-1:0]      rd_exp_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic                  rd_valid_b,
    input  logic [WIDTH-1:0]      rd_exp_b,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    input  logic [WIDTH-1:0]      data_out_a,
    input  logic [WIDTH-1:0]      data_out_b,
    output logic [7:0]            err_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic                  fail_port,
    output logic                  any_fail
);

    typedef struct packed {
        logic                  valid;
        logic [WIDTH-1:0]      expected;
        logic [ADDR_WIDTH-1:0] addr;
        logic                  port;
    } pend_t;

    pend_t      pend_a;
    pend_t      pend_b;
    logic       mism_a;
    logic       mism_b;
    logic [8:0] err_sum;

    // Capture the expectation of this cycle's reads; compared next cycle.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset || clear) begin
            // NOTE: payload fields are cleared along with valid; it costs little and keeps X out of the compare.
            pend_a <= '0;
            pend_b <= '0;
        end else begin
            pend_a <= '{valid: rd_valid_a, expected: rd_exp_a, addr: rd_addr_a, port: 1'b0};
            pend_b <= '{valid: rd_valid_b, expected: rd_exp_b, addr: rd_addr_b, port: 1'b1};
        end
    end

    assign mism_a = pend_a.valid && (data_out_a != pend_a.expected);
    assign mism_b = pend_b.valid && (data_out_b != pend_b.expected);

    // Both ports can fail in one cycle, so the count may step by two.
    always_comb err_sum = {1'b0, err_count} + {8'd0, mism_a} + {8'd0, mism_b};

    // Error count and first-fail capture; port A wins a same-cycle tie.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            err_count <= '0;
            fail_addr <= '0;
            fail_port <= 1'b0;
            any_fail  <= 1'b0;
        end else begin
            err_count <= err_sum[8] ? 8'hFF : err_sum[7:0];
            if (!any_fail && (mism_a || mism_b)) begin
                any_fail  <= 1'b1;
                fail_addr <= mism_a ? pend_a.addr : pend_b.addr;
                fail_port <= mism_a ? pend_a.port : pend_b.port;
            end
        end
    end

endmodule

// File: rtl/dual_sram_bist.sv
// March C- BIST controller for the dual-port SRAM. Both ports run the march
// concurrently over disjoint address halves, then a cross-port phase writes
// each word through A and reads it back through B.
module dual_sram_bist
    import dual_sram_bist_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  fail,
    output logic [7:0]            err_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic                  fail_port,
    output logic                  chip_sel,
    output logic                  read_ena_a,
    output logic                  read_ena_b,
    output logic [ADDR_WIDTH-1:0] address_a,
    output logic [ADDR_WIDTH-1:0] address_b,
    output logic [WIDTH-1:0]      data_in_a,
    output logic [WIDTH-1:0]      data_in_b,
    input  logic [WIDTH-1:0]      data_out_a,
    input  logic [WIDTH-1:0]      data_out_b
);

    localparam logic [ADDR_WIDTH-1:0] HALF     = ADDR_WIDTH'(DEPTH / 2);
    localparam logic [ADDR_WIDTH-1:0] LAST_REL = ADDR_WIDTH'(DEPTH / 2 - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ABS = ADDR_WIDTH'(DEPTH - 1);

    function automatic logic [WIDTH-1:0] bg_word(input bg_e bg);
        return WIDTH'(background(bg, WIDTH));
    endfunction

    state_e                state, state_next;
    logic [ADDR_WIDTH-1:0] idx, idx_next;    // relative index in march, absolute in XP
    logic                  sub, sub_next;    // 0 = read step, 1 = write step of a pair
    march_elem_t           elem;
    state_e                phase_after;
    logic                  do_read, do_write, last_op, last_idx;
    logic                  rd_valid_a, rd_valid_b;
    logic [WIDTH-1:0]      rd_exp_a, rd_exp_b;
    logic                  start_accept;
    logic                  any_fail;

    assign start_accept = (state == ST_IDLE) && start;

    // Sequencer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            idx   <= '0;
            sub   <= 1'b0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            sub   <= sub_next;
        end
    end

    // Next-state sequencing and SRAM/compare drive for the current step.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_next  = state;
        idx_next    = idx;
        sub_next    = sub;
        busy        = 1'b0;
        done        = 1'b0;
        chip_sel    = 1'b0;
        read_ena_a  = 1'b1;
        read_ena_b  = 1'b1;
        address_a   = '0;
        address_b   = '0;
        data_in_a   = '0;
        data_in_b   = '0;
        rd_valid_a  = 1'b0;
        rd_valid_b  = 1'b0;
        rd_exp_a    = '0;
        rd_exp_b    = '0;
        elem        = march_elem(state);
        phase_after = next_phase(state);
        do_read     = 1'b0;
        do_write    = 1'b0;
        last_op     = 1'b0;
        last_idx    = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_M0;
                    idx_next   = '0;
                    sub_next   = 1'b0;
                end
            end

            ST_M0, ST_M1, ST_M2, ST_M3, ST_M4, ST_M5: begin
                busy      = 1'b1;
                chip_sel  = 1'b1;
                address_a = idx;
                address_b = idx + HALF;
                // Read/write elements take two cycles per index: read, then write.
                do_read   = elem.has_rd && !sub;
                do_write  = elem.has_wr && (sub || !elem.has_rd);
                last_op   = !(elem.has_rd && elem.has_wr) || sub;
                last_idx  = (elem.dir == DIR_UP) ? (idx == LAST_REL) : (idx == '0);
                if (do_read) begin
                    rd_valid_a = 1'b1;
                    rd_valid_b = 1'b1;
                    rd_exp_a   = bg_word(elem.rd_bg);
                    rd_exp_b   = bg_word(elem.rd_bg);
                end
                if (do_write) begin
                    read_ena_a = 1'b0;
                    read_ena_b = 1'b0;
                    data_in_a  = bg_word(elem.wr_bg);
                    data_in_b  = bg_word(elem.wr_bg);
                end
                if (last_op) begin
                    sub_next = 1'b0;
                    if (last_idx) begin
                        state_next = phase_after;
                        idx_next   = (elem_dir(phase_after) == DIR_DOWN) ? LAST_REL : '0;
                    end else begin
                        idx_next = (elem.dir == DIR_UP) ? idx + 1'b1 : idx - 1'b1;
                    end
                end else begin
                    sub_next = 1'b1;
                end
            end

            ST_XP: begin
                busy      = 1'b1;
                chip_sel  = 1'b1;
                address_a = idx;
                address_b = idx;
                if (!sub) begin
                    // A writes the pattern; B idles as an unchecked read.
                    read_ena_a = 1'b0;
                    data_in_a  = bg_word(BG_P);
                    sub_next   = 1'b1;
                end else begin
                    rd_valid_b = 1'b1;
                    rd_exp_b   = bg_word(BG_P);
                    sub_next   = 1'b0;
                    if (idx == LAST_ABS) begin
                        state_next = ST_DRAIN;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end
            end

            ST_DRAIN: begin
                // Final XP read is compared in this cycle.
                busy       = 1'b1;
                state_next = ST_DONE;
            end

            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end

            default: state_next = ST_IDLE;
        endcase
    end

    dual_sram_bist_check #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_check (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_accept),
        .rd_valid_a (rd_valid_a),
        .rd_exp_a   (rd_exp_a),
        .rd_addr_a  (address_a),
        .rd_valid_b (rd_valid_b),
        .rd_exp_b   (rd_exp_b),
        .rd_addr_b  (address_b),
        .data_out_a (data_out_a),
        .data_out_b (data_out_b),
        .err_count  (err_count),
        .fail_addr  (fail_addr),
        .fail_port  (fail_port),
        .any_fail   (any_fail)
    );

    // Verdict: cleared on start, set as the run completes.
    always_ff @(posedge clk) begin
        if (reset || start_accept) begin
            pass <= 1'b0;
            fail <= 1'b0;
        end else if (state == ST_DONE) begin
            pass <= !any_fail;
            fail <= any_fail;
        end
    end

endmodule

// File: tb/tb_dual_sram_bist.sv
// Self-checking bench for dual_sram_bist: a behavioural dual-port SRAM with
// stuck-at faults, a March C- reference model over plain arrays, and a bus
// monitor watching port separation and chip_sel.
`timescale 1ns/1ps
module tb_dual_sram_bist;

    localparam int WIDTH      = 8;
    localparam int DEPTH      = 8;
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int H          = DEPTH / 2;
    localparam int MARCH_LEN  = H + 8 * H + H;
    localparam int BUSY_LEN   = MARCH_LEN + 2 * DEPTH + 1;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic                  busy, done, pass, fail, fail_port, chip_sel;
    logic [7:0]            err_count;
    logic [ADDR_WIDTH-1:0] fail_addr, address_a, address_b;
    logic                  read_ena_a, read_ena_b;
    logic [WIDTH-1:0]      data_in_a, data_in_b;
    logic [WIDTH-1:0]      data_out_a = '0;
    logic [WIDTH-1:0]      data_out_b = '0;

    dual_sram_bist #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail       (fail),
        .err_count  (err_count),
        .fail_addr  (fail_addr),
        .fail_port  (fail_port),
        .chip_sel   (chip_sel),
        .read_ena_a (read_ena_a),
        .read_ena_b (read_ena_b),
        .address_a  (address_a),
        .address_b  (address_b),
        .data_in_a  (data_in_a),
        .data_in_b  (data_in_b),
        .data_out_a (data_out_a),
        .data_out_b (data_out_b)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- SRAM model with stuck-at faults ----------------
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] sa0 [DEPTH];
    logic [WIDTH-1:0] sa1 [DEPTH];

    function automatic logic [WIDTH-1:0] seen(input logic [WIDTH-1:0] v, input int a);
        return (v | sa1[a]) & ~sa0[a];
    endfunction

    always @(posedge clk) begin
        if (chip_sel) begin
            if (read_ena_a)  data_out_a <= seen(mem[address_a], int'(address_a));
            if (read_ena_b)  data_out_b <= seen(mem[address_b], int'(address_b));
            if (!read_ena_a) mem[address_a] <= data_in_a;
            if (!read_ena_b) mem[address_b] <= data_in_b;
        end
    end

    task automatic clear_faults();
        for (int a = 0; a < DEPTH; a++) begin
            sa0[a] = '0;
            sa1[a] = '0;
        end
    endtask

    // ---------------- bus monitor ----------------
    int bus_viol = 0;
    int mon_cyc  = 0;   // busy cycles already seen in the current run

    always @(negedge clk) begin
        mon_cyc <= busy ? mon_cyc + 1 : 0;
        if (!busy && chip_sel)
            bus_viol <= bus_viol + 1;
        if (busy && mon_cyc < MARCH_LEN && chip_sel &&
            (int'(address_a) >= H || int'(address_b) < H ||
             (address_a == address_b && (!read_ena_a || !read_ena_b))))
            bus_viol <= bus_viol + 1;
        if (busy && mon_cyc >= MARCH_LEN && !read_ena_b)
            bus_viol <= bus_viol + 1;
    end

    // ---------------- reference model ----------------
    function automatic logic [WIDTH-1:0] alt_pattern();
        logic [WIDTH-1:0] v;
        for (int i = 0; i < WIDTH; i++) v[i] = ((WIDTH - 1 - i) % 2) == 0;
        return v;
    endfunction

    // March C- on both halves then the cross-port pass, over the faulty array.
    task automatic model_run(output int errs, output int faddr, output int fport);
        logic [WIDTH-1:0] m [DEPTH];
        logic [WIDTH-1:0] rv, wv;
        bit               has_rd, has_wr, down, got_fail;
        int               i, a;
        errs = 0; faddr = 0; fport = 0; got_fail = 0;
        for (int k = 0; k < DEPTH; k++) m[k] = '0;
        for (int e = 0; e < 6; e++) begin
            has_rd = (e != 0);
            has_wr = (e != 5);
            down   = (e == 3 || e == 4);
            rv     = (e == 2 || e == 4) ? '1 : '0;
            wv     = (e == 1 || e == 3) ? '1 : '0;
            for (int k = 0; k < H; k++) begin
                i = down ? H - 1 - k : k;
                if (has_rd) begin
                    for (int p = 0; p < 2; p++) begin
                        a = i + p * H;
                        if (seen(m[a], a) != rv) begin
                            if (errs < 255) errs++;
                            if (!got_fail) begin got_fail = 1; faddr = a; fport = p; end
                        end
                    end
                end
                if (has_wr) begin
                    m[i]     = wv;
                    m[i + H] = wv;
                end
            end
        end
        for (int k = 0; k < DEPTH; k++) begin
            m[k] = alt_pattern();
            if (seen(m[k], k) != alt_pattern()) begin
                if (errs < 255) errs++;
                if (!got_fail) begin got_fail = 1; faddr = k; fport = 1; end
            end
        end
    endtask

    // ---------------- stimulus tasks ----------------
    task automatic check_idle(input string tag);
        check({tag, "_busy"},      32'(busy),       32'd0);
        check({tag, "_done"},      32'(done),       32'd0);
        check({tag, "_pass"},      32'(pass),       32'd0);
        check({tag, "_fail"},      32'(fail),       32'd0);
        check({tag, "_err_count"}, 32'(err_count),  32'd0);
        check({tag, "_fail_addr"}, 32'(fail_addr),  32'd0);
        check({tag, "_fail_port"}, 32'(fail_port),  32'd0);
        check({tag, "_chip_sel"},  32'(chip_sel),   32'd0);
        check({tag, "_rd_ena"},    32'({read_ena_a, read_ena_b}), 32'd3);
        check({tag, "_addr"},      32'({address_a, address_b}),   32'd0);
        check({tag, "_din"},       32'({data_in_a, data_in_b}),   32'd0);
    endtask

    task automatic run_bist(input string tag, input int repulse_1, input int repulse_2);
        int         cyc, busy_n, done_n, done_at, viol0;
        int         exp_errs, exp_addr, exp_port;
        logic [7:0] err_at1;
        logic       pass_at1, fail_at1;
        model_run(exp_errs, exp_addr, exp_port);
        viol0 = bus_viol;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 0; busy_n = 0; done_n = 0; done_at = 0;
        err_at1 = '1; pass_at1 = 1'b1; fail_at1 = 1'b1;
        while (cyc < 4 * BUSY_LEN && (done_at == 0 || cyc < done_at + 3)) begin
            @(negedge clk);
            cyc++;
            start = (cyc == repulse_1 || cyc == repulse_2);
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at == 0) done_at = cyc;
            end
            if (cyc == 1) begin
                err_at1 = err_count; pass_at1 = pass; fail_at1 = fail;
            end
        end
        start = 1'b0;
        check({tag, "_cleared_err"},  32'(err_at1),   32'd0);
        check({tag, "_cleared_flag"}, 32'({pass_at1, fail_at1}), 32'd0);
        check({tag, "_busy_len"},     busy_n,         BUSY_LEN);
        check({tag, "_done_count"},   done_n,         32'd1);
        check({tag, "_done_cycle"},   done_at,        BUSY_LEN + 1);
        check({tag, "_pass"},         32'(pass),      32'(exp_errs == 0));
        check({tag, "_fail"},         32'(fail),      32'(exp_errs != 0));
        check({tag, "_err_count"},    32'(err_count), exp_errs);
        check({tag, "_fail_addr"},    32'(fail_addr), exp_addr);
        check({tag, "_fail_port"},    32'(fail_port), exp_port);
        check({tag, "_bus_mon"},      bus_viol - viol0, 32'd0);
    endtask

    task automatic abort_run();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'd1);
        check("abort_err_before",  32'(err_count != 0), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_idle("abort");
        reset = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    int na, nb;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        clear_faults();
        for (int a = 0; a < DEPTH; a++) mem[a] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("por");
        reset = 1'b0;

        // start coincident with reset must be dropped
        @(negedge clk);
        reset = 1'b1; start = 1'b1;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        check("rst_start_busy", 32'(busy), 32'd0);

        // fault-free run with ignored re-pulses of start
        run_bist("clean", 5, 40);
        check("clean_pass_direct", 32'(pass), 32'd1);

        // bit 0 of address 5 stuck at 1
        clear_faults();
        sa1[5][0] = 1'b1;
        run_bist("sa1_a5", 0, 0);
        check("sa1_a5_direct", 32'({err_count, fail_addr, fail_port}), 32'({8'd4, 3'd5, 1'b1}));

        // bit 7 of address 2 stuck at 0
        clear_faults();
        sa0[2][7] = 1'b1;
        run_bist("sa0_a2", 0, 0);
        check("sa0_a2_direct", 32'({err_count, fail_addr, fail_port}), 32'({8'd3, 3'd2, 1'b0}));

        // reset in the middle of a failing run, then a clean run
        clear_faults();
        sa1[5][0] = 1'b1;
        abort_run();
        clear_faults();
        run_bist("after_abort", 0, 0);
        check("after_abort_direct", 32'({pass, fail}), 32'd2);

        // random stuck-at faults
        for (int r = 0; r < 6; r++) begin
            clear_faults();
            na = $urandom_range(0, 3);
            for (int f = 0; f < na; f++) begin
                nb = $urandom_range(0, DEPTH - 1);
                if ($urandom_range(0, 1) == 1) sa1[nb][$urandom_range(0, WIDTH - 1)] = 1'b1;
                else                           sa0[nb][$urandom_range(0, WIDTH - 1)] = 1'b1;
            end
            run_bist($sformatf("rand%0d", r), $urandom_range(2, BUSY_LEN - 1), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
